// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and the
// data path (DM). One access in flight at a time; data wins ties unless fetch starves.
module mem_port_arbiter #(
  parameter int MEM_LATENCY    = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ready,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SCW = $clog2(MAX_DATA_BURST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  // Handshake: a request transfers on a clock edge where req && ready are both
  // high. ready is only ever raised in IDLE, for the single selected requester.
  state_e            state_q, state_d;
  logic [SCW-1:0]    starve_q, starve_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic              owner_dm_q, owner_dm_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              busy_q, busy_d;

  logic starve_full;
  logic grant_dm;
  logic grant_if;
  logic idle;

  always_comb begin
    starve_full = (starve_q == SCW'(MAX_DATA_BURST));
    grant_dm    = dm_req && !(if_req && starve_full);
    grant_if    = if_req && !grant_dm;
    idle        = (state_q == IDLE);
    if_ready    = idle && grant_if && !reset;
    dm_ready    = idle && grant_dm && !reset;

    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    owner_dm_d  = owner_dm_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_dm || grant_if) begin
          state_d    = ISSUE;
          owner_dm_d = grant_dm;
          addr_d     = grant_dm ? dm_addr : if_addr;
          we_d       = grant_dm && dm_we;
          mem_en_d   = 1'b1;
          mem_we_d   = grant_dm && dm_we;
          if (grant_dm) wdata_d = dm_wdata;
          // Fetch starvation only accrues while fetch is actually waiting.
          if (grant_if) starve_d = '0;
          else if (if_req && !starve_full) starve_d = starve_q + SCW'(1);
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          wait_d  = WCW'(MEM_LATENCY - 1);
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = RESP;
          if (owner_dm_q) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          wait_d = wait_q - WCW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      owner_dm_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      owner_dm_q  <= owner_dm_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

endmodule
